store_align_buffer: RTL and testbench

Store-side counterpart of the MEM-stage load extension path. It takes SB/SH/SW stores from the EXE/MEM pipeline register, checks alignment, replicates the store data into lane position, generates per-byte write strobes, and holds the stores in a small FIFO. The FIFO drains to the data cache over a req/ack write port. It also stalls the pipeline when the FIFO is full, or when a load hits a word that still has a buffered store.

---
 rtl/store_align_buffer_if.sv | 42 ++++
 rtl/store_align_buffer.sv | 126 ++++++++++++
 tb/tb_store_align_buffer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_align_buffer_if.sv
// Store-path bundle: EXE/MEM store inputs, hazard/exception flags and the
// data-cache write port. The DUT takes the slave view, the driver the master view.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef Store
`define Store 7'b0100011
`endif
`ifndef Load
`define Load 7'b0000011
`endif

interface store_align_buffer_if;
  logic [6:0]            opcode_EXE_MEM;
  logic [2:0]            funct3_EXE_MEM;
  logic                  store_valid;
  logic [`DATA_SIZE-1:0] store_addr;
  logic [`DATA_SIZE-1:0] store_data;
  logic                  Dcache_wreq;
  logic [`DATA_SIZE-1:0] Dcache_waddr;
  logic [`DATA_SIZE-1:0] Dcache_wdata;
  logic [3:0]            Dcache_wstrb;
  logic                  Dcache_wack;
  logic                  store_stall;
  logic                  load_stall;
  logic                  store_misaligned;
  logic                  buf_empty;

  modport slave (
    input  opcode_EXE_MEM, funct3_EXE_MEM, store_valid, store_addr, store_data,
    input  Dcache_wack,
    output Dcache_wreq, Dcache_waddr, Dcache_wdata, Dcache_wstrb,
    output store_stall, load_stall, store_misaligned, buf_empty
  );

  modport master (
    output opcode_EXE_MEM, funct3_EXE_MEM, store_valid, store_addr, store_data,
    output Dcache_wack,
    input  Dcache_wreq, Dcache_waddr, Dcache_wdata, Dcache_wstrb,
    input  store_stall, load_stall, store_misaligned, buf_empty
  );
endinterface

// File: rtl/store_align_buffer.sv
// Store alignment/lane formatting in front of a small in-order write FIFO
// that drains to the data cache, with full and load-hit stall generation.
module store_align_buffer #(
  parameter int BUF_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  store_align_buffer_if.slave sab
);
  localparam int DW    = `DATA_SIZE;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

  logic [DW-1:0]    addr_q [BUF_DEPTH];
  logic [DW-1:0]    addr_d [BUF_DEPTH];
  logic [DW-1:0]    data_q [BUF_DEPTH];
  logic [DW-1:0]    data_d [BUF_DEPTH];
  logic [3:0]       strb_q [BUF_DEPTH];
  logic [3:0]       strb_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             misaligned_q, misaligned_d;

  logic          is_store, is_load, width_ok, aligned, legal;
  logic          full, push, pop, wreq, hit;
  logic [DW-1:0] fmt_data;
  logic [3:0]    fmt_strb;

  // Decode the request, check alignment and place data into byte lanes.
  always_comb begin
    is_store = sab.store_valid && (sab.opcode_EXE_MEM == `Store);
    is_load  = sab.store_valid && (sab.opcode_EXE_MEM == `Load);
    width_ok = 1'b1;
    aligned  = 1'b1;
    fmt_data = sab.store_data;
    fmt_strb = 4'b1111;
    case (sab.funct3_EXE_MEM)
      3'b000: begin
        fmt_data = {4{sab.store_data[7:0]}};
        fmt_strb = 4'b0001 << sab.store_addr[1:0];
      end
      3'b001: begin
        aligned  = ~sab.store_addr[0];
        fmt_data = {2{sab.store_data[15:0]}};
        fmt_strb = sab.store_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: aligned = (sab.store_addr[1:0] == 2'b00);
      default: width_ok = 1'b0;
    endcase
    legal        = is_store && width_ok && aligned;
    misaligned_d = is_store && width_ok && !aligned;
    full         = (count_q == DEPTH_C);
    wreq         = (count_q != '0);
    push         = legal && !full;
    pop          = wreq && sab.Dcache_wack;
  end

  // Next FIFO contents, pointers and occupancy.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      addr_d[wr_ptr_q] = {sab.store_addr[DW-1:2], 2'b00};
      data_d[wr_ptr_q] = fmt_data;
      strb_d[wr_ptr_q] = fmt_strb;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A load stalls if any occupied slot holds its word address.
  always_comb begin
    logic [PTR_W-1:0] offset;
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) &&
          (addr_q[i][DW-1:2] == sab.store_addr[DW-1:2]))
        hit = 1'b1;
    end
  end

  // State registers; reset discards all pending stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Write port is driven only from the head slot, zeroed while idle.
  assign sab.Dcache_wreq      = wreq;
  assign sab.Dcache_waddr     = wreq ? addr_q[rd_ptr_q] : '0;
  assign sab.Dcache_wdata     = wreq ? data_q[rd_ptr_q] : '0;
  assign sab.Dcache_wstrb     = wreq ? strb_q[rd_ptr_q] : '0;
  assign sab.store_stall      = legal && full;
  assign sab.load_stall       = is_load && hit;
  assign sab.store_misaligned = misaligned_q;
  assign sab.buf_empty        = !wreq;
endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_store_align_buffer;
  localparam int DEPTH = 2;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  logic        exp_mis = 1'b0;

  store_align_buffer_if sab();

  store_align_buffer #(.BUF_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sab  (sab)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Spec rules for a store request: width legality, alignment, lane image.
  function automatic void rules(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                output logic wok, output logic al,
                                output logic [31:0] wd, output logic [3:0] st);
    wok = (f3 <= 3'd2);
    al  = (f3 == 3'd0) || (f3 == 3'd1 && a[0] == 1'b0) || (f3 == 3'd2 && a[1:0] == 2'd0);
    wd  = d;
    st  = 4'hF;
    if (f3 == 3'd0) begin
      wd = {4{d[7:0]}};
      st = 4'(1 << a[1:0]);
    end else if (f3 == 3'd1) begin
      wd = {2{d[15:0]}};
      st = a[1] ? 4'b1100 : 4'b0011;
    end
  endfunction

  // Model advance at each clock edge.
  always @(posedge clk) begin
    logic wok, al, is_st;
    logic [31:0] wd;
    logic [3:0] st;
    int sz;
    if (rst_n) begin
      rules(sab.funct3_EXE_MEM, sab.store_addr, sab.store_data, wok, al, wd, st);
      is_st = sab.store_valid && sab.opcode_EXE_MEM == OP_ST;
      sz = q_addr.size();
      if (sz > 0 && sab.Dcache_wack) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        void'(q_strb.pop_front());
      end
      if (is_st && wok && al && sz < DEPTH) begin
        q_addr.push_back({sab.store_addr[31:2], 2'b00});
        q_data.push_back(wd);
        q_strb.push_back(st);
      end
      exp_mis = is_st && wok && !al;
    end
  end

  // Reset empties the model immediately.
  always @(negedge rst_n) begin
    q_addr.delete();
    q_data.delete();
    q_strb.delete();
    exp_mis = 1'b0;
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    logic wok, al, is_st, is_ld, match;
    logic [31:0] wd;
    logic [3:0] st;
    if (rst_n) begin
      rules(sab.funct3_EXE_MEM, sab.store_addr, sab.store_data, wok, al, wd, st);
      is_st = sab.store_valid && sab.opcode_EXE_MEM == OP_ST;
      is_ld = sab.store_valid && sab.opcode_EXE_MEM == OP_LD;
      match = 1'b0;
      foreach (q_addr[i]) if (q_addr[i][31:2] == sab.store_addr[31:2]) match = 1'b1;
      chk("wreq", 32'(sab.Dcache_wreq), 32'(q_addr.size() != 0));
      chk("buf_empty", 32'(sab.buf_empty), 32'(q_addr.size() == 0));
      if (q_addr.size() != 0) begin
        chk("waddr", sab.Dcache_waddr, q_addr[0]);
        chk("wdata", sab.Dcache_wdata, q_data[0]);
        chk("wstrb", 32'(sab.Dcache_wstrb), 32'(q_strb[0]));
      end
      chk("store_stall", 32'(sab.store_stall), 32'(is_st && wok && al && q_addr.size() == DEPTH));
      chk("load_stall", 32'(sab.load_stall), 32'(is_ld && match));
      chk("misaligned", 32'(sab.store_misaligned), 32'(exp_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic ack);
    sab.store_valid    = v;
    sab.opcode_EXE_MEM = op;
    sab.funct3_EXE_MEM = f3;
    sab.store_addr     = a;
    sab.store_data     = d;
    sab.Dcache_wack    = ack;
  endtask

  initial begin
    drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wreq", 32'(sab.Dcache_wreq), 32'd0);
    chk("rst_empty", 32'(sab.buf_empty), 32'd1);
    chk("rst_waddr", sab.Dcache_waddr, 32'd0);
    chk("rst_wdata", sab.Dcache_wdata, 32'd0);
    chk("rst_wstrb", 32'(sab.Dcache_wstrb), 32'd0);
    chk("rst_mis", 32'(sab.store_misaligned), 32'd0);
    chk("rst_sstall", 32'(sab.store_stall), 32'd0);
    chk("rst_lstall", 32'(sab.load_stall), 32'd0);
    rst_n = 1'b1;
    step();

    // SB to top byte lane, drained immediately
    drive(1'b1, OP_ST, 3'b000, 32'h1003, 32'h0000_00AB, 1'b1);
    step();
    drive(1'b0, OP_ST, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sb_wreq", 32'(sab.Dcache_wreq), 32'd1);
    chk("sb_waddr", sab.Dcache_waddr, 32'h1000);
    chk("sb_wdata", sab.Dcache_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", 32'(sab.Dcache_wstrb), 32'h8);
    step();
    @(negedge clk);
    chk("sb_empty", 32'(sab.buf_empty), 32'd1);

    // SH + SW held, third store stalls, then drain in order
    step();
    drive(1'b1, OP_ST, 3'b001, 32'h2002, 32'h0000_1234, 1'b0);
    step();
    drive(1'b1, OP_ST, 3'b010, 32'h2004, 32'hDEAD_BEEF, 1'b0);
    step();
    drive(1'b1, OP_ST, 3'b010, 32'h2008, 32'h5555_5555, 1'b0);
    @(negedge clk);
    chk("full_stall", 32'(sab.store_stall), 32'd1);
    chk("sh_wdata", sab.Dcache_wdata, 32'h1234_1234);
    chk("sh_wstrb", 32'(sab.Dcache_wstrb), 32'hC);
    step();
    drive(1'b0, OP_ST, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sh_stable", sab.Dcache_wdata, 32'h1234_1234);
    step();
    drive(1'b0, OP_ST, 3'b000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sw_waddr", sab.Dcache_waddr, 32'h2004);
    chk("sw_wstrb", 32'(sab.Dcache_wstrb), 32'hF);
    sab.Dcache_wack = 1'b1;
    step();
    sab.Dcache_wack = 1'b0;
    @(negedge clk);
    chk("drained", 32'(sab.buf_empty), 32'd1);

    // misaligned SH then SW: consecutive pulses, never enqueued
    step();
    drive(1'b1, OP_ST, 3'b001, 32'h3001, 32'h1, 1'b0);
    step();
    drive(1'b1, OP_ST, 3'b010, 32'h3002, 32'h2, 1'b0);
    @(negedge clk);
    chk("mis1", 32'(sab.store_misaligned), 32'd1);
    chk("mis_nostall", 32'(sab.store_stall), 32'd0);
    step();
    drive(1'b0, OP_ST, 3'b000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mis2", 32'(sab.store_misaligned), 32'd1);
    step();
    @(negedge clk);
    chk("mis_end", 32'(sab.store_misaligned), 32'd0);
    chk("mis_empty", 32'(sab.buf_empty), 32'd1);

    // load hazard on a buffered word
    step();
    drive(1'b1, OP_ST, 3'b010, 32'h4000, 32'h0BAD_F00D, 1'b0);
    step();
    drive(1'b1, OP_LD, 3'b010, 32'h4002, 32'h0, 1'b0);
    @(negedge clk);
    chk("ld_hit", 32'(sab.load_stall), 32'd1);
    step();
    drive(1'b1, OP_LD, 3'b010, 32'h4004, 32'h0, 1'b0);
    @(negedge clk);
    chk("ld_miss", 32'(sab.load_stall), 32'd0);
    step();
    drive(1'b1, OP_LD, 3'b010, 32'h4002, 32'h0, 1'b1);
    step();
    drive(1'b1, OP_LD, 3'b010, 32'h4002, 32'h0, 1'b0);
    @(negedge clk);
    chk("ld_after_pop", 32'(sab.load_stall), 32'd0);

    // asynchronous reset with two pending stores
    step();
    drive(1'b1, OP_ST, 3'b010, 32'h6000, 32'h1111_1111, 1'b0);
    step();
    drive(1'b1, OP_ST, 3'b010, 32'h6004, 32'h2222_2222, 1'b0);
    step();
    drive(1'b0, OP_ST, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_wreq", 32'(sab.Dcache_wreq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wreq", 32'(sab.Dcache_wreq), 32'd0);
    chk("arst_empty", 32'(sab.buf_empty), 32'd1);
    chk("arst_waddr", sab.Dcache_waddr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sab.Dcache_wack = 1'b1;
    repeat (4) step();
    chk("post_rst_wreq", 32'(sab.Dcache_wreq), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int r;
      r  = int'($urandom_range(0, 7));
      op = (r < 4) ? OP_ST : (r < 6) ? OP_LD : OP_AL;
      f3 = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 8, op, f3, 32'h5000 + $urandom_range(0, 31),
            $urandom, $urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, OP_AL, 3'd0, 32'h0, 32'h0, 1'b1);
    repeat (DEPTH + 2) step();
    chk("final_empty", 32'(sab.buf_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
